// File: rtl/core_pkg.sv
// Shared constants and types for the core front end.
package core_pkg;

   localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous flop-based FIFO with flush; the head is read straight from the
// storage array, so a pushed entry becomes visible the cycle after the push.
module core_fetch_fifo #(
   parameter type          T     = logic [31:0],
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
   input  logic            clk_i,
   input  logic            srst_i,
   input  logic            flush_i,
   input  logic            push_i,
   input  T                wdata_i,
   input  logic            pop_i,
   output T                rdata_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T                r_mem [DEPTH];
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;
   logic            w_push;
   logic            w_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (r_count == CntW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign rdata_o = r_mem[r_rd_ptr];

   // A pop frees the slot in the same cycle, so push on a full FIFO is legal with a pop.
   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   always_ff @(posedge clk_i) begin
      if (srst_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop) begin
            r_count <= r_count + CntW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response
// buffering and redirect handling with discard of stale in-flight responses.
module core_fetch #(
   parameter logic [31:0] BOOT_ADDR  = core_pkg::BOOT_ADDR,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        srst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instruction_o,
   output logic        instruction_valid_o,
   output logic [31:0] id_pc_o,
   input  logic        stall_i
);

   import core_pkg::*;

   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned UsedW = CntW + 1;

   logic [31:0]     r_pc;
   logic [31:0]     r_pend_pc;
   logic            r_pend_valid;
   logic            r_req_hold;
   logic [CntW-1:0] r_discard;

   logic [31:0]     w_pc_d;
   logic [31:0]     w_pend_pc_d;
   logic            w_pend_valid_d;
   logic [CntW-1:0] w_discard_d;

   logic [CntW-1:0] w_outstanding;
   logic [CntW-1:0] w_out_nxt;
   logic [CntW-1:0] w_count;
   logic [UsedW-1:0] w_used;
   logic            w_addr_full;
   logic            w_addr_empty;
   logic            w_instr_full;
   logic            w_instr_empty;
   logic            w_req;
   logic            w_grant;
   logic            w_rsp;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic [31:0]     w_rsp_pc;
   fetch_entry_t    w_wentry;
   fetch_entry_t    w_head;

   // A redirect flushes the buffer, so the head is not consumed in that cycle.
   assign w_pop = !w_instr_empty && !stall_i && !redirect_i;

   // Credit counts the slot freed by this cycle's pop so a depth-2 buffer streams at full rate.
   assign w_used = {1'b0, w_outstanding} + {1'b0, w_count} - UsedW'(w_pop);
   assign w_req  = !srst_i && !w_addr_full &&
                   (r_req_hold || (w_used < UsedW'(FIFO_DEPTH)));

   assign w_grant   = w_req && imem_gnt_i;
   assign w_rsp     = imem_rvalid_i && !w_addr_empty;
   assign w_drop    = w_rsp && (redirect_i || (r_discard != '0));
   assign w_push    = w_rsp && !w_drop && (!w_instr_full || w_pop);
   assign w_out_nxt = w_outstanding + CntW'(w_grant) - CntW'(w_rsp);
   assign w_wentry  = '{pc: w_rsp_pc, instr: imem_rdata_i};

   assign imem_req_o  = w_req;
   assign imem_addr_o = r_pc;

   assign instruction_valid_o = !w_instr_empty;
   assign instruction_o       = instruction_valid_o ? w_head.instr : NOP_INST;
   assign id_pc_o             = instruction_valid_o ? w_head.pc : 32'h0;

   always_comb begin
      w_pc_d         = r_pc;
      w_pend_pc_d    = r_pend_pc;
      w_pend_valid_d = r_pend_valid;
      w_discard_d    = r_discard;

      if (w_grant) w_pc_d = r_pc + 32'd4;
      if (w_rsp && (r_discard != '0)) w_discard_d = r_discard - CntW'(1);

      // The request that was pending when an earlier redirect hit is stale.
      if (w_grant && r_pend_valid) begin
         w_pc_d         = r_pend_pc;
         w_pend_valid_d = 1'b0;
         w_discard_d    = w_discard_d + CntW'(1);
      end

      if (redirect_i) begin
         w_discard_d = w_out_nxt;
         if (!w_req || w_grant) begin
            w_pc_d         = align_word(redirect_pc_i);
            w_pend_valid_d = 1'b0;
         end else begin
            w_pend_valid_d = 1'b1;
            w_pend_pc_d    = align_word(redirect_pc_i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_pc         <= BOOT_ADDR;
         r_pend_pc    <= 32'h0;
         r_pend_valid <= 1'b0;
         r_req_hold   <= 1'b0;
         r_discard    <= '0;
      end else begin
         r_pc         <= w_pc_d;
         r_pend_pc    <= w_pend_pc_d;
         r_pend_valid <= w_pend_valid_d;
         r_req_hold   <= w_req && !imem_gnt_i;
         r_discard    <= w_discard_d;
      end
   end

   core_fetch_fifo #(
      .T     (logic [31:0]),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_q (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .flush_i (1'b0),
      .push_i  (w_grant),
      .wdata_i (r_pc),
      .pop_i   (w_rsp),
      .rdata_o (w_rsp_pc),
      .full_o  (w_addr_full),
      .empty_o (w_addr_empty),
      .count_o (w_outstanding)
   );

   core_fetch_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_q (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .flush_i (redirect_i),
      .push_i  (w_push),
      .wdata_i (w_wentry),
      .pop_i   (w_pop),
      .rdata_o (w_head),
      .full_o  (w_instr_full),
      .empty_o (w_instr_empty),
      .count_o (w_count)
   );

endmodule
